modexp_word_port: RTL and testbench

- Word-serial I/O front end on the ModExp side of the RSA/Paillier datapath.
- Deserializes operand words (message, exponent, modulus, r, t) streamed by the top-level controller into wide operand registers, then launches the exponentiation core.
- Reports progress on `exp_state` and streams the wide core result back out one word per cycle on `res_out`.

---
 rtl/modexp_word_port.sv | 182 ++++++++++++++++++
 tb/tb_modexp_word_port.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_word_port.sv
// modexp_word_port: word-serial operand loader and result streamer for the
// ModExp core. Five operand buses are deserialized into wide registers, the
// core is launched, and the wide result is returned one word per cycle.
// Optional build macro: MODEXP_PORT_ZEROIZE_EN clears all operand, constant
// and result storage on every return to IDLE so key material is not retained.

module modexp_word_port #(
    parameter int DATA_WIDTH  = 128,
    parameter int DATA_NUMBER = 32,
    localparam int W          = DATA_WIDTH * DATA_NUMBER
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  startInput,
    input  logic                  startCompute,
    input  logic                  getResult,
    input  logic [DATA_WIDTH-1:0] m_buf,
    input  logic [DATA_WIDTH-1:0] e_buf,
    input  logic [DATA_WIDTH-1:0] n_buf,
    input  logic [DATA_WIDTH-1:0] r_buf,
    input  logic [DATA_WIDTH-1:0] t_buf,
    input  logic [DATA_WIDTH-1:0] nprime0,
    output logic [W-1:0]          m_wide,
    output logic [W-1:0]          e_wide,
    output logic [W-1:0]          n_wide,
    output logic [W-1:0]          r_wide,
    output logic [W-1:0]          t_wide,
    output logic [DATA_WIDTH-1:0] nprime0_q,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [W-1:0]          core_result,
    output logic [4:0]            exp_state,
    output logic [DATA_WIDTH-1:0] res_out,
    output logic                  load_err
);

    localparam logic [4:0] S_IDLE     = 5'd0;
    localparam logic [4:0] S_LOAD     = 5'd1;
    localparam logic [4:0] S_ARMED    = 5'd2;
    localparam logic [4:0] S_BUSY     = 5'd3;
    localparam logic [4:0] S_COMPLETE = 5'd9;
    localparam logic [4:0] S_DRAIN    = 5'd10;

    localparam logic [4:0] LAST_IDX = 5'(DATA_NUMBER - 1);

    logic [4:0]   state;
    logic [4:0]   word_cnt;
    logic         get_result_q;
    logic         drain_last;
    logic [W-1:0] result_q;
    logic         load_abort;

    // A load is abandoned when compute is requested early or the controller drops startInput
    assign load_abort = (state == S_LOAD) && (startCompute || !startInput);

    assign exp_state = state;

`ifdef MODEXP_PORT_ZEROIZE_EN
    logic going_idle;

    // Every path that lands back in IDLE, used to wipe stored secrets
    assign going_idle = load_abort
                     || ((state == S_BUSY) && core_done && !get_result_q)
                     || ((state == S_DRAIN) && drain_last);
`endif

    // Control FSM: sequences load, launch, completion and the result drain.
    // drain_last distinguishes the final DRAIN cycle because the 5-bit counter
    // has already wrapped back to zero by then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            word_cnt     <= '0;
            core_start   <= 1'b0;
            load_err     <= 1'b0;
            get_result_q <= 1'b0;
            drain_last   <= 1'b0;
        end else begin
            core_start <= 1'b0;
            load_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (startInput) begin
                        state    <= S_LOAD;
                        word_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_abort) begin
                        load_err <= 1'b1;
                        state    <= S_IDLE;
                        word_cnt <= '0;
                    end else begin
                        word_cnt <= word_cnt + 5'd1;
                        if (word_cnt == LAST_IDX) begin
                            state <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (startCompute) begin
                        get_result_q <= getResult;
                        core_start   <= 1'b1;
                        state        <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (core_done) begin
                        state <= get_result_q ? S_COMPLETE : S_IDLE;
                    end
                end
                S_COMPLETE: begin
                    state      <= S_DRAIN;
                    word_cnt   <= '0;
                    drain_last <= 1'b0;
                end
                S_DRAIN: begin
                    if (drain_last) begin
                        state      <= S_IDLE;
                        drain_last <= 1'b0;
                        word_cnt   <= '0;
                    end else begin
                        word_cnt <= word_cnt + 5'd1;
                        if (word_cnt == LAST_IDX) begin
                            drain_last <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: operand deserialization, constant latch, result capture and word streaming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wide    <= '0;
            e_wide    <= '0;
            n_wide    <= '0;
            r_wide    <= '0;
            t_wide    <= '0;
            nprime0_q <= '0;
            result_q  <= '0;
            res_out   <= '0;
        end else begin
            if ((state == S_LOAD) && !load_abort) begin
                m_wide[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= m_buf;
                e_wide[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= e_buf;
                n_wide[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= n_buf;
                r_wide[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= r_buf;
                t_wide[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= t_buf;
            end
            if ((state == S_ARMED) && startCompute) begin
                nprime0_q <= nprime0;
            end
            if ((state == S_BUSY) && core_done) begin
                result_q <= core_result;
                if (get_result_q) begin
                    res_out <= core_result[DATA_WIDTH-1:0];
                end
            end
            if ((state == S_DRAIN) && !drain_last) begin
                res_out <= result_q[word_cnt*DATA_WIDTH +: DATA_WIDTH];
            end
`ifdef MODEXP_PORT_ZEROIZE_EN
            if (going_idle) begin
                m_wide    <= '0;
                e_wide    <= '0;
                n_wide    <= '0;
                r_wide    <= '0;
                t_wide    <= '0;
                nprime0_q <= '0;
                result_q  <= '0;
                res_out   <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_modexp_word_port.sv
// tb_modexp_word_port: directed, table-driven bench for modexp_word_port.
// Honors MODEXP_PORT_ZEROIZE_EN when choosing post-IDLE expectations.

module tb_modexp_word_port;

    localparam int DW = 128;
    localparam int DN = 32;
    localparam int W  = DW * DN;

    logic          clk = 1'b0;
    logic          rst;
    logic          startInput, startCompute, getResult;
    logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
    logic [W-1:0]  m_wide, e_wide, n_wide, r_wide, t_wide;
    logic [DW-1:0] nprime0_q;
    logic          core_start;
    logic          core_done;
    logic [W-1:0]  core_result;
    logic [4:0]    exp_state;
    logic [DW-1:0] res_out;
    logic          load_err;

    int checks = 0;
    int errors = 0;
    int startPulses = 0;
    int errPulses = 0;
    int completeCycles = 0;

    typedef struct {
        int         offset;
        logic [4:0] state;
        logic [DW-1:0] res;
    } drainVec_t;

    drainVec_t drainTable[8];

    modexp_word_port #(.DATA_WIDTH(DW), .DATA_NUMBER(DN)) dut (
        .clk(clk), .rst(rst),
        .startInput(startInput), .startCompute(startCompute), .getResult(getResult),
        .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
        .nprime0(nprime0),
        .m_wide(m_wide), .e_wide(e_wide), .n_wide(n_wide), .r_wide(r_wide), .t_wide(t_wide),
        .nprime0_q(nprime0_q), .core_start(core_start), .core_done(core_done),
        .core_result(core_result), .exp_state(exp_state), .res_out(res_out),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Pulse and state monitors sampled on the inactive edge
    always @(negedge clk) begin
        if (core_start) startPulses++;
        if (load_err) errPulses++;
        if (exp_state == 5'd9) completeCycles++;
    end

    function automatic logic [DW-1:0] busWord(input int bus, input int k, input int seed);
        return DW'((seed << 16) | (bus << 12) | (k + 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic si, input logic sc, input logic gr, input logic cd);
        startInput   = si;
        startCompute = sc;
        getResult    = gr;
        core_done    = cd;
        tick();
    endtask

    task automatic driveWord(input int k, input int seed);
        m_buf = busWord(0, k, seed);
        e_buf = busWord(1, k, seed);
        n_buf = busWord(2, k, seed);
        r_buf = busWord(3, k, seed);
        t_buf = busWord(4, k, seed);
    endtask

    // Starts a load and streams nwords words, leaving startInput high
    task automatic loadWords(input int nwords, input int seed);
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < nwords; k++) begin
            driveWord(k, seed);
            applyStimulus(1, 0, 0, 0);
        end
    endtask

    task automatic checkOperands(input string tag, input int seed, input logic zero);
        for (int k = 0; k < DN; k++) begin
            checkOutput($sformatf("%s m_wide[%0d]", tag, k), m_wide[k*DW +: DW],
                        zero ? '0 : busWord(0, k, seed));
            checkOutput($sformatf("%s e_wide[%0d]", tag, k), e_wide[k*DW +: DW],
                        zero ? '0 : busWord(1, k, seed));
            checkOutput($sformatf("%s n_wide[%0d]", tag, k), n_wide[k*DW +: DW],
                        zero ? '0 : busWord(2, k, seed));
            checkOutput($sformatf("%s r_wide[%0d]", tag, k), r_wide[k*DW +: DW],
                        zero ? '0 : busWord(3, k, seed));
            checkOutput($sformatf("%s t_wide[%0d]", tag, k), t_wide[k*DW +: DW],
                        zero ? '0 : busWord(4, k, seed));
        end
    endtask

    initial begin
        logic zeroize;
        logic [DW-1:0] lastRes;
        int cur;
`ifdef MODEXP_PORT_ZEROIZE_EN
        zeroize = 1'b1;
`else
        zeroize = 1'b0;
`endif
        drainTable[0] = '{0,  5'd9,  DW'(32'h100)};
        drainTable[1] = '{1,  5'd10, DW'(32'h100)};
        drainTable[2] = '{2,  5'd10, DW'(32'h100)};
        drainTable[3] = '{3,  5'd10, DW'(32'h101)};
        drainTable[4] = '{18, 5'd10, DW'(32'h110)};
        drainTable[5] = '{32, 5'd10, DW'(32'h11E)};
        drainTable[6] = '{33, 5'd10, DW'(32'h11F)};
        drainTable[7] = '{34, 5'd0,  zeroize ? '0 : DW'(32'h11F)};

        rst = 1'b1;
        startInput = 0; startCompute = 0; getResult = 0; core_done = 0;
        m_buf = '0; e_buf = '0; n_buf = '0; r_buf = '0; t_buf = '0;
        nprime0 = '0;
        core_result = '0;
        for (int k = 0; k < DN; k++) core_result[k*DW +: DW] = DW'(32'h100 + k);
        tick();
        tick();
        checkOutput("reset exp_state", DW'(exp_state), '0);
        checkOutput("reset res_out", res_out, '0);
        checkOutput("reset core_start", DW'(core_start), '0);
        checkOutput("reset load_err", DW'(load_err), '0);
        checkOutput("reset m_wide[0]", m_wide[DW-1:0], '0);
        checkOutput("reset nprime0_q", nprime0_q, '0);
        rst = 1'b0;
        tick();

        // Normal load, compute with result return
        loadWords(DN, 0);
        checkOutput("armed exp_state", DW'(exp_state), DW'(2));
        checkOperands("load", 0, 1'b0);
        nprime0 = DW'(32'hCAFE_F00D);
        applyStimulus(0, 1, 1, 0);
        checkOutput("launch core_start", DW'(core_start), DW'(1));
        checkOutput("launch exp_state", DW'(exp_state), DW'(3));
        checkOutput("launch nprime0_q", nprime0_q, DW'(32'hCAFE_F00D));
        applyStimulus(0, 0, 0, 0);
        checkOutput("core_start one cycle", DW'(core_start), '0);
        checkOutput("busy holds", DW'(exp_state), DW'(3));
        applyStimulus(0, 0, 0, 1);
        core_done = 0;
        cur = 0;
        for (int i = 0; i < 8; i++) begin
            while (cur < drainTable[i].offset) begin
                tick();
                cur++;
            end
            checkOutput($sformatf("drain C+%0d exp_state", cur), DW'(exp_state),
                        DW'(drainTable[i].state));
            checkOutput($sformatf("drain C+%0d res_out", cur), res_out, drainTable[i].res);
        end
        tick();
        checkOutput("post-drain res_out hold", res_out, zeroize ? '0 : DW'(32'h11F));
        checkOperands("post-drain", 0, zeroize);
        checkOutput("post-drain nprime0_q", nprime0_q, zeroize ? '0 : DW'(32'hCAFE_F00D));
        lastRes = res_out;

        // Requests that must be ignored in IDLE
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("idle startCompute ignored", DW'(exp_state), '0);
        checkOutput("idle core_done ignored", res_out, lastRes);
        applyStimulus(0, 0, 0, 0);

        // Early startCompute at word 10
        loadWords(10, 2);
        driveWord(10, 2);
        applyStimulus(1, 1, 0, 0);
        checkOutput("early sc load_err", DW'(load_err), DW'(1));
        checkOutput("early sc exp_state", DW'(exp_state), '0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("load_err one cycle", DW'(load_err), '0);
        if (zeroize) checkOutput("abort zeroize m_wide[0]", m_wide[DW-1:0], '0);

        // startInput dropped mid-load
        loadWords(4, 3);
        applyStimulus(0, 0, 0, 0);
        checkOutput("drop si load_err", DW'(load_err), DW'(1));
        checkOutput("drop si exp_state", DW'(exp_state), '0);
        applyStimulus(0, 0, 0, 0);

        // getResult low: completion returns straight to IDLE
        for (int k = 0; k < DN; k++) core_result[k*DW +: DW] = DW'(32'h500 + k);
        loadWords(DN, 1);
        checkOutput("gr0 armed", DW'(exp_state), DW'(2));
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        core_done = 0;
        checkOutput("gr0 exp_state", DW'(exp_state), '0);
        checkOutput("gr0 res_out unchanged", res_out, lastRes);
        applyStimulus(0, 0, 0, 0);
        checkOutput("gr0 stays idle", DW'(exp_state), '0);
        checkOperands("gr0", 1, zeroize);

        // Reset asserted mid-load at word 5
        loadWords(5, 4);
        driveWord(5, 4);
        startInput = 1;
        rst = 1'b1;
        #1;
        checkOutput("rst mid-load exp_state", DW'(exp_state), '0);
        checkOutput("rst mid-load m_wide[0]", m_wide[DW-1:0], '0);
        checkOutput("rst mid-load t_wide[4]", t_wide[4*DW +: DW], '0);
        checkOutput("rst mid-load res_out", res_out, '0);
        checkOutput("rst mid-load nprime0_q", nprime0_q, '0);
        tick();
        startInput = 0;
        rst = 1'b0;
        tick();
        checkOutput("after rst exp_state", DW'(exp_state), '0);
        checkOutput("after rst core_start", DW'(core_start), '0);

        checkOutput("core_start pulse count", DW'(startPulses), DW'(2));
        checkOutput("load_err pulse count", DW'(errPulses), DW'(2));
        checkOutput("COMPLETE cycle count", DW'(completeCycles), DW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
